serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Receive-side counterpart of the team's parallel-load shift register.
- Captures an LSB-first serial bit stream, qualified by a bit strobe and a word-sync marker, into BIT-wide words.
- Presents each completed word on a registered valid/ready output port, with overflow and resync error reporting.
- Sits between a serial link front end and any parallel consumer.

Parameters:
BIT, 8, data word width in bits; legal range BIT >= 2

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rstn  input  1  asynchronous active-low reset
i_serial  input  1  serial data bit, sampled only when i_sen=1
i_sen  input  1  bit strobe; one bit captured per rising edge with i_sen=1
i_sync  input  1  marks the strobed bit as bit 0 of a new word; ignored when i_sen=0
i_ready  input  1  consumer accepts o_parrel on an edge where o_valid=1 and i_ready=1
i_clr  input  1  synchronous clear of o_overflow
o_parrel  output  BIT  received word, LSB = first bit received
o_valid  output  1  o_parrel holds an unconsumed word
o_overflow  output  1  sticky: a completed word was dropped
o_sync_err  output  1  one-cycle pulse: partial word discarded by resync
o_perr  output  1  parity error for the word on o_parrel; 0 when PARITY_EN is not defined

Behaviour:
- Reset: async on i_rstn=0. All outputs 0, shift register 0, bit counter 0, FSM=IDLE. Reset mid-word discards the partial word with no flags.
- Shift path: on each strobe, shreg <= {i_serial, shreg[BIT-1:1]}. Counter cnt is $clog2(BIT) bits wide.
- FSM IDLE:
  - strobe with i_sync=0: ignored.
  - strobe with i_sync=1: capture bit as bit 0, cnt=1, go to SHIFT.
- FSM SHIFT:
  - strobe with i_sync=0: capture, cnt++.
  - On the strobe capturing bit BIT-1: word complete, cnt=0, go to IDLE, or to PARITY under PARITY_EN.
  - strobe with i_sync=1 (resync): discard partial word, capture this bit as new bit 0, cnt=1, stay in SHIFT, pulse o_sync_err for 1 cycle.
- Completion latency: o_valid=1 and o_parrel=word on the edge after the last-bit strobe (1 clock).
- Back-to-back words: in IDLE, a sync strobe on the very next cycle after completion is accepted.
- Output handshake: o_valid and o_parrel hold stable until an edge with i_ready=1, which clears o_valid. i_ready while o_valid=0 has no effect.
- Completion on the same edge as acceptance (o_valid=1, i_ready=1): old word consumed, new word loaded, o_valid stays 1, no overflow.
- Completion while o_valid=1 and i_ready=0: new word dropped, o_parrel unchanged, o_overflow set.
- o_overflow clears only on i_clr=1. If i_clr=1 and an overflow occur on the same edge, the set wins.
- Resync on the same edge as a completion is impossible by construction: the completing strobe is itself the one evaluated.

Optional Feature:
- Macro: PARITY_EN.
- Defined:
  - Extra FSM state PARITY. After the BIT-th data bit, the next strobe carries an even parity bit.
  - Completion occurs on the parity strobe, so o_valid is registered 1 clock after the parity strobe.
  - o_perr = XOR(data bits, parity bit); it is valid and held together with o_parrel.
  - A strobe with i_sync=1 in PARITY is treated as a resync: o_sync_err pulse, data discarded, go to SHIFT with cnt=1.
- Not defined: no PARITY state, completion on the BIT-th data bit, o_perr tied 0.

Test Plan:
1. Send 8'h55 LSB-first, sync on first bit, i_sen every cycle, i_ready=1 -> o_valid=1 for exactly 1 cycle, 1 clock after the 8th strobe; o_parrel=8'h55; o_overflow=0.
2. Send 8'h55 with i_sen asserted every 3rd cycle and i_serial toggled between strobes -> same result, 8'h55; non-strobed values never captured.
3. Send 8'hC3 then 8'h0F back-to-back with i_ready=0 -> o_parrel holds 8'hC3, o_overflow=1 after the second word; i_ready pulse clears o_valid; i_clr clears o_overflow.
4. Send 4 bits, then sync strobe followed by 8'hA5 -> o_sync_err pulses once; o_parrel=8'hA5; no overflow.
5. Drive i_rstn=0 for 1 cycle after 5 bits of 8'h3C, then send full 8'h3C -> all outputs 0 during reset; afterwards o_parrel=8'h3C.
6. With PARITY_EN: send 8'h55 + parity 0 -> o_perr=0; send 8'h55 + parity 1 -> o_perr=1, o_parrel=8'h55 in both cases.

Source files
------------

// File: rtl/serial_deserializer.sv
// serial_deserializer: LSB-first serial-to-parallel receiver with word sync.
// Optional even-parity bit per word when compiled with PARITY_EN.
//
// Parameters:
//   BIT        data word width (>= 2)
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_serial   serial data bit, sampled when i_sen=1
//   i_sen      bit strobe
//   i_sync     strobed bit is bit 0 of a new word
//   i_ready    consumer accepts o_parrel when o_valid=1
//   i_clr      synchronous clear of o_overflow
//   o_parrel   received word, LSB = first bit received
//   o_valid    o_parrel holds an unconsumed word
//   o_overflow sticky: a completed word was dropped
//   o_sync_err one-cycle pulse: partial word discarded by resync
//   o_perr     parity error for o_parrel (0 without PARITY_EN)
module serial_deserializer #(
    parameter int BIT = 8
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_serial,
    input  logic           i_sen,
    input  logic           i_sync,
    input  logic           i_ready,
    input  logic           i_clr,
    output logic [BIT-1:0] o_parrel,
    output logic           o_valid,
    output logic           o_overflow,
    output logic           o_sync_err,
    output logic           o_perr
);

    localparam int CW = $clog2(BIT);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
    // Full word stays in the shift register until the parity strobe.
    localparam int SW = BIT;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
    // The last data bit comes straight from i_serial, so only
    // BIT-1 bits need to be held.
    localparam int SW = BIT - 1;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [BIT-1:0]  parrel_q, parrel_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            serr_q, serr_d;
    logic [SW-1:0]   shifted;
    logic [BIT-1:0]  word;
    logic            done;
    logic            resync;

`ifdef PARITY_EN
    logic            perr_q, perr_d;
    logic            perr_calc;

    assign shifted = {i_serial, shreg_q[SW-1:1]};
`else
    logic [BIT-1:0]  ext;

    assign ext     = {i_serial, shreg_q};
    assign shifted = ext[BIT-1:1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        resync  = 1'b0;
        word    = parrel_q;
`ifdef PARITY_EN
        perr_calc = 1'b0;
`endif
        if (i_sen) begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_sync) begin
                        shreg_d = shifted;
                        cnt_d   = ONE;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // A new bit 0 simply shifts in; stale bits of the
                    // abandoned word fall out before the word completes.
                    shreg_d = shifted;
                    if (i_sync) begin
                        resync = 1'b1;
                        cnt_d  = ONE;
                    end else if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PARITY_EN
                        state_d = S_PARITY;
`else
                        done    = 1'b1;
                        word    = ext;
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (i_sync) begin
                        resync  = 1'b1;
                        shreg_d = shifted;
                        cnt_d   = ONE;
                        state_d = S_SHIFT;
                    end else begin
                        done      = 1'b1;
                        word      = shreg_q;
                        perr_calc = ^{shreg_q, i_serial};
                        state_d   = S_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        valid_d  = valid_q;
        parrel_d = parrel_q;
        ovf_d    = ovf_q;
        serr_d   = resync;
`ifdef PARITY_EN
        perr_d   = perr_q;
`endif
        if (i_clr) begin
            ovf_d = 1'b0;
        end
        if (done) begin
            // The slot is free if empty or drained on this same edge.
            if (!valid_q || i_ready) begin
                valid_d  = 1'b1;
                parrel_d = word;
`ifdef PARITY_EN
                perr_d   = perr_calc;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            parrel_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            parrel_q <= parrel_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            serr_q   <= serr_d;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign o_perr = perr_q;
`else
    assign o_perr = 1'b0;
`endif

    assign o_parrel   = parrel_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_sync_err = serr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed stimulus against a word-level model
// of the receiver, plus literal expectations for each scenario.
module tb_serial_deserializer;

    localparam int BIT = 8;
`ifdef PARITY_EN
    localparam int TOTAL = BIT + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int TOTAL = BIT;
    localparam bit PAR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           serial = 1'b0;
    logic           sen = 1'b0;
    logic           sync = 1'b0;
    logic           ready = 1'b0;
    logic           clr = 1'b0;
    logic [BIT-1:0] parrel;
    logic           valid;
    logic           ovf;
    logic           serr;
    logic           perr;

    int checks = 0;
    int failures = 0;
    int serr_seen = 0;

    serial_deserializer #(.BIT(BIT)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_serial  (serial),
        .i_sen     (sen),
        .i_sync    (sync),
        .i_ready   (ready),
        .i_clr     (clr),
        .o_parrel  (parrel),
        .o_valid   (valid),
        .o_overflow(ovf),
        .o_sync_err(serr),
        .o_perr    (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Word-level model: bits gathered since the last sync strobe.
    bit             m_in = 0;
    int             m_n = 0;
    logic [BIT-1:0] m_word = '0;
    logic           m_par = 0;
    logic [BIT-1:0] m_parrel = '0;
    logic           m_valid = 0;
    logic           m_ovf = 0;
    logic           m_serr = 0;
    logic           m_perr = 0;

    always @(posedge clk or negedge rstn) begin
        bit fin;
        bit set_ovf;
        if (!rstn) begin
            m_in = 0; m_n = 0; m_word = '0; m_par = 0;
            m_parrel = '0; m_valid = 0; m_ovf = 0;
            m_serr = 0; m_perr = 0;
        end else begin
            fin = 0;
            set_ovf = 0;
            m_serr = 0;
            if (sen) begin
                if (sync) begin
                    if (m_in) m_serr = 1;
                    m_in = 1;
                    m_word = '0;
                    m_word[0] = serial;
                    m_n = 1;
                end else if (m_in) begin
                    if (m_n < BIT) m_word[m_n] = serial;
                    else m_par = serial;
                    m_n++;
                    if (m_n == TOTAL) begin
                        fin = 1;
                        m_in = 0;
                    end
                end
            end
            if (fin) begin
                if (!m_valid || ready) begin
                    m_parrel = m_word;
                    m_perr = PAR ? (^m_word ^ m_par) : 1'b0;
                    m_valid = 1;
                end else begin
                    set_ovf = 1;
                end
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (set_ovf) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(valid), 32'(m_valid));
        if (m_valid) chk("parrel", 32'(parrel), 32'(m_parrel));
        if (m_valid) chk("perr", 32'(perr), 32'(m_perr));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("sync_err", 32'(serr), 32'(m_serr));
        if (serr) serr_seen++;
    end

    task automatic strobe(input logic b, input logic s);
        serial = b;
        sync = s;
        sen = 1'b1;
        @(negedge clk);
        sen = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            serial = ~serial;
            @(negedge clk);
        end
    endtask

    task automatic send_raw(input logic [BIT-1:0] w, input int gap);
        for (int i = 0; i < BIT; i++) begin
            strobe(w[i], i == 0);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic send_word(input logic [BIT-1:0] w, input int gap);
        send_raw(w, gap);
`ifdef PARITY_EN
        strobe(^w, 1'b0);
        if (gap > 0) idle(gap);
`endif
    endtask

    initial begin
        int s0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_parrel", 32'(parrel), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: contiguous strobes, consumer always ready
        ready = 1'b1;
        send_word(8'h55, 0);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_parrel", 32'(parrel), 32'h55);
        @(negedge clk);
        chk("t1_valid_1cyc", 32'(valid), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        idle(2);

        // 2: strobe every 3rd cycle, serial toggling between strobes
        send_word(8'h55, 2);
        chk("t2_parrel", 32'(parrel), 32'h55);
        idle(2);

        // 3: two words back-to-back with consumer stalled
        ready = 1'b0;
        send_word(8'hC3, 0);
        send_word(8'h0F, 0);
        chk("t3_parrel", 32'(parrel), 32'hC3);
        chk("t3_ovf", 32'(ovf), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("t3_drained", 32'(valid), 32'd0);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t3_clr", 32'(ovf), 32'd0);

        // 4: partial word abandoned by a new sync
        ready = 1'b1;
        s0 = serr_seen;
        strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        send_word(8'hA5, 0);
        chk("t4_parrel", 32'(parrel), 32'hA5);
        idle(2);
        chk("t4_serr_once", 32'(serr_seen - s0), 32'd1);
        chk("t4_ovf", 32'(ovf), 32'd0);

        // 5: reset in the middle of a word
        for (int i = 0; i < 5; i++) begin
            logic [BIT-1:0] w;
            w = 8'h3C;
            strobe(w[i], i == 0);
        end
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_parrel", 32'(parrel), 32'd0);
        chk("t5_rst_serr", 32'(serr), 32'd0);
        chk("t5_rst_perr", 32'(perr), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        send_word(8'h3C, 0);
        chk("t5_parrel", 32'(parrel), 32'h3C);
        chk("t5_ovf", 32'(ovf), 32'd0);
        idle(2);

`ifdef PARITY_EN
        // 6: explicit parity bits
        send_raw(8'h55, 0);
        strobe(1'b0, 1'b0);
        chk("t6_parrel0", 32'(parrel), 32'h55);
        chk("t6_perr0", 32'(perr), 32'd0);
        idle(2);
        send_raw(8'h55, 0);
        strobe(1'b1, 1'b0);
        chk("t6_parrel1", 32'(parrel), 32'h55);
        chk("t6_perr1", 32'(perr), 32'd1);
        idle(2);
`else
        chk("t6_perr_tied", 32'(perr), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
